// File: rtl/bus_target_ram.sv
// rtl/bus_target_ram.sv - bus target serving single/block reads and writes from an internal word RAM
module bus_target_ram #(
    parameter logic [2:0]  DEV_ID      = 3'd1,
    parameter logic [26:0] BASE_ADDR   = 27'h0000000,
    parameter int          DEPTH       = 256,
    parameter int          BLOCK_WORDS = 4
) (
    input  logic        clock_i,
    input  logic        resetn_i,
    input  logic [2:0]  reqdev_i,
    input  logic        req_i,
    input  logic        req_block_i,
    input  logic        rw_i,
    input  logic [26:0] add_i,
    input  logic [31:0] data_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic        done_o,
    output logic [31:0] data_o,
    output logic        exception_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  BMASK    = AW'(BLOCK_WORDS - 1);
    localparam logic [27:0]    WIN_LO   = {1'b0, BASE_ADDR};
    localparam logic [27:0]    WIN_SIZE = 28'(4 * DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] beat_q, beat_d;
    logic          rw_q, rw_d;
    logic          blk_q, blk_d;
    logic [31:0]   data_q, data_d;

    logic [31:0]   ram [DEPTH];

    logic [27:0]   offset;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          hit;
    logic          accept;
    logic          last_beat;
    logic          ram_we;

    // Beat k of a transfer wraps inside its block-aligned group, so the requested word comes first.
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input logic [AW-1:0] k);
        return (base & ~BMASK) | ((base + k) & BMASK);
    endfunction

    // Window decode: a single 28-bit unsigned offset compare; addresses below the base wrap to huge offsets.
    always_comb begin
        offset    = {1'b0, add_i} - WIN_LO;
        hit       = offset < WIN_SIZE;
        req_idx   = AW'(offset >> 2);
        accept    = req_i && (state_q == S_IDLE) && (reqdev_i == DEV_ID);
        last_beat = !blk_q || (beat_q == BMASK);
        cur_addr  = beat_addr(idx_q, beat_q);
    end

    assign rd_data = ram[rd_addr];

    // Next-state logic; read data is fetched one cycle ahead so data_o is registered yet aligned with valid_o.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        rw_d    = rw_q;
        blk_d   = blk_q;
        data_d  = data_q;
        ram_we  = 1'b0;
        rd_addr = req_idx;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rw_d   = rw_i;
                    blk_d  = req_block_i;
                    idx_d  = req_idx;
                    beat_d = '0;
                    if (hit) begin
                        state_d = S_XFER;
                        if (!rw_i) begin
                            data_d = rd_data;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_XFER: begin
                if (rw_q) begin
                    ram_we = 1'b1;
                end else if (!last_beat) begin
                    rd_addr = beat_addr(idx_q, beat_q + 1'b1);
                    data_d  = rd_data;
                end
                if (last_beat) begin
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and read-data registers; reset returns to idle at once.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            beat_q  <= '0;
            rw_q    <= 1'b0;
            blk_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            rw_q    <= rw_d;
            blk_q   <= blk_d;
            data_q  <= data_d;
        end
    end

    // RAM array is deliberately not reset so contents survive a reset.
    always_ff @(posedge clock_i) begin
        if (ram_we) begin
            ram[cur_addr] <= data_i;
        end
    end

    assign ready_o     = (state_q == S_IDLE);
    assign valid_o     = (state_q == S_XFER);
    assign done_o      = (state_q == S_DONE) || (state_q == S_ERR);
    assign exception_o = (state_q == S_ERR);
    assign data_o      = data_q;

endmodule

// File: doc/bus_target_ram.md
# bus_target_ram

Memory-bus responder for the request/ready/valid/done protocol driven by the JTAG UART communication controller and other bus initiators. Decodes a device ID and a byte address window, then serves single-word or fixed-length block reads and writes from an internal word-addressed RAM. Reports out-of-window accesses through `exception_o`. Sits on the target side of the bus, opposite the initiator's `reqdev/req/req_block/rw/add/data` outputs.

## Interface
Parameters:
- `DEV_ID`, 3'd1, value of `reqdev_i` this target answers.
- `BASE_ADDR`, 27'h0000000, byte base of window; must be 4-byte aligned.
- `DEPTH`, 256, RAM words; power of two.
- `BLOCK_WORDS`, 4, beats per block transfer; power of two, ≤ `DEPTH`.

Ports:
- `clock_i` input 1: single clock, rising edge.
- `resetn_i` input 1: asynchronous, active-low reset.
- `reqdev_i` input 3: target device select.
- `req_i` input 1: request strobe.
- `req_block_i` input 1: 1 = block of `BLOCK_WORDS` beats, 0 = single beat.
- `rw_i` input 1: 1 = write, 0 = read.
- `add_i` input 27: byte address; bits [1:0] ignored.
- `data_i` input 32: write beat data.
- `ready_o` output 1: idle, can accept a request.
- `valid_o` output 1: beat strobe (read data valid / write beat captured).
- `done_o` output 1: one-cycle end-of-transfer pulse.
- `data_o` output 32: read beat data.
- `exception_o` output 1: one-cycle pulse, address outside window.

## Operation
- Accept: cycle T with `req_i & ready_o & (reqdev_i == DEV_ID)`. Latch `rw_i`, `req_block_i`, word index `idx = (add_i - BASE_ADDR) >> 2`. Other `reqdev_i` values: no response, no state change.
- Window hit: `BASE_ADDR <= add_i < BASE_ADDR + 4*DEPTH` (unsigned, 27-bit compare, no overflow on upper bound computation; use 28 bits). Miss → ERR.
- States: IDLE, XFER, DONE, ERR.
  - IDLE: `ready_o`=1. Accept+hit → XFER, beat counter=0. Accept+miss → ERR.
  - XFER: one beat per cycle, `valid_o`=1 each cycle. Read: `data_o` = RAM[addr_k]. Write: RAM[addr_k] ← `data_i` sampled that cycle. After last beat (beat 0 single, beat `BLOCK_WORDS-1` block) → DONE.
  - DONE: `done_o`=1 one cycle → IDLE.
  - ERR: `exception_o`=1 and `done_o`=1 same cycle, no `valid_o`, no RAM write → IDLE.
- Beat address: `addr_k = {idx[hi:log2 BLOCK_WORDS], (idx[log2 BLOCK_WORDS-1:0] + k) mod BLOCK_WORDS}` — wraps within the block-aligned group (critical word first). Single beat: `addr_0 = idx`.
- `req_i` while not IDLE: ignored; initiator must re-present after `ready_o` returns.
- `data_o` holds last read beat when `valid_o`=0; don't-care for writes (holds previous value).
- Reset: any state → IDLE immediately; RAM contents not reset (undefined after power-up, retained across reset).

## Timing
- Reset values: `ready_o`=1, `valid_o`=0, `done_o`=0, `exception_o`=0, `data_o`=0.
- Accept at T: `ready_o`=0 from T+1.
- Beat k at T+1+k; read data registered, valid in same cycle as `valid_o`.
- Write beat k: initiator drives `data_i` in cycle T+1+k.
- Single: `done_o` at T+2, `ready_o`=1 at T+3. Block: `done_o` at T+1+`BLOCK_WORDS`, `ready_o`=1 the cycle after.
- Error: `exception_o`=`done_o`=1 at T+1, `ready_o`=1 at T+2.
- Back-to-back: earliest next accept is the first cycle `ready_o`=1.
- Reset asserted mid-transfer: outputs to reset values asynchronously; partially written block keeps beats already captured.

## Test plan
- Single write 0xDEADBEEF to BASE+0x10, then single read BASE+0x10 → `valid_o` at T+1 with `data_o`=0xDEADBEEF, `done_o` at T+2, `ready_o` at T+3.
- Block write 0x11,0x22,0x33,0x44 at BASE+0x20; block read at BASE+0x28 → beats 0x33,0x44,0x11,0x22 on consecutive cycles, `done_o` after 4th beat.
- Read at BASE+4*DEPTH and BASE−4 → `exception_o`=`done_o`=1 at T+1, no `valid_o`, RAM unchanged.
- `reqdev_i`≠`DEV_ID` with `req_i`=1 for 5 cycles → no output change; `req_i` pulsed mid-block → ignored, block completes normally.
- Assert `resetn_i`=0 after beat 1 of a block write → all outputs reset immediately; readback shows beats 0–1 written, beats 2–3 old data.
- Single read at BASE+0x13 → returns word at BASE+0x10 (byte bits ignored).
